// File: rtl/ctrl_word_encoder.sv
// ctrl_word_encoder: table-driven control word encoder with condition gating and a moc handshake
module ctrl_word_encoder #(
  parameter int STATE_W     = 7,
  parameter int CW_W        = 48,
  parameter int TO_W        = 4,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [STATE_W-1:0] state,
  input  logic               cond,
  input  logic               ir_s,
  input  logic               moc,
  input  logic               tbl_we,
  input  logic [STATE_W-1:0] tbl_addr,
  input  logic [CW_W-1:0]    tbl_wdata,
  input  logic               err_clr,
  output logic [CW_W-1:0]    ctrl,
  output logic               stall,
  output logic               err_timeout
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, RELEASE} fsm_t;
  fsm_t                fsm;
  logic [CW_W-1:0]     tbl [2**STATE_W];
  logic [CW_W-1:0]     raw, keep, gated;
  logic [TO_W-1:0]     cnt;
  // gate the looked-up word: SQ drops FRLd without S, CQ drops all enables on false cond
  always_comb begin
    raw   = tbl[state];
    keep  = raw & {{(CW_W-12){1'b1}}, 5'b0, ~(raw[7] & ~ir_s), 6'h3F};
    gated = (raw[8] & ~cond) ? (keep & {{(CW_W-12){1'b1}}, 12'h0}) : keep;
  end
  // control word table; write lands at the edge so a same-cycle lookup sees the old word
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 2**STATE_W; i++) tbl[i] <= '0;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end
  // lookup / memory-wait / release sequencing with timeout and sticky error
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      fsm         <= RUN;
      ctrl        <= '0;
      stall       <= 1'b0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (err_clr) err_timeout <= 1'b0;
      case (fsm)
        RUN: begin
          ctrl <= gated;
          if (gated[5]) begin
            fsm   <= MEM_WAIT;
            stall <= 1'b1;
            cnt   <= '0;
          end
        end
        MEM_WAIT: begin
          if (moc || cnt == TO_W'(MOC_TIMEOUT - 1)) begin
            fsm   <= RELEASE;
            ctrl  <= '0;
            stall <= 1'b0;
            if (!moc) err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          fsm  <= RUN;
          ctrl <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_word_encoder.sv
// tb_ctrl_word_encoder: scoreboard bench with a cycle-level behavioural model
module tb_ctrl_word_encoder;
  localparam int STATE_W = 7, CW_W = 48, TO_W = 4, MOC_TIMEOUT = 15;
  logic               CLK = 0, CLR = 0;
  logic [STATE_W-1:0] state = '0, tbl_addr = '0;
  logic               cond = 0, ir_s = 0, moc = 0, tbl_we = 0, err_clr = 0;
  logic [CW_W-1:0]    tbl_wdata = '0;
  logic [CW_W-1:0]    ctrl;
  logic               stall, err_timeout;
  ctrl_word_encoder #(.STATE_W(STATE_W), .CW_W(CW_W), .TO_W(TO_W), .MOC_TIMEOUT(MOC_TIMEOUT)) dut (
    .CLK(CLK), .CLR(CLR), .state(state), .cond(cond), .ir_s(ir_s), .moc(moc),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .err_clr(err_clr),
    .ctrl(ctrl), .stall(stall), .err_timeout(err_timeout));
  always #5 CLK = ~CLK;
  int total = 0, bad = 0;
  logic [CW_W+1:0] exp_q [$];
  // reference model: what the datapath should see each cycle
  logic [CW_W-1:0] m_tbl [128];
  logic [CW_W-1:0] m_ctrl = '0;
  logic            m_stall = 0, m_err = 0, m_busy = 0, m_rel = 0;
  int              m_waited = 0;
  function automatic logic [CW_W-1:0] decode(input logic [CW_W-1:0] w, input logic c, input logic s);
    logic [CW_W-1:0] en, pass;
    pass = (w >> 12) << 12;
    en   = w % 128;
    if (w[7] && !s) en = en - (en & 48'h40);
    if (w[8] && !c) en = 0;
    return pass + en;
  endfunction
  task automatic model_edge();
    logic [CW_W-1:0] looked;
    if (!CLR) begin
      foreach (m_tbl[i]) m_tbl[i] = '0;
      m_ctrl = '0; m_stall = 0; m_err = 0; m_busy = 0; m_rel = 0; m_waited = 0;
      return;
    end
    looked = decode(m_tbl[state], cond, ir_s);
    if (err_clr) m_err = 0;
    if (m_busy) begin
      if (moc) begin
        m_busy = 0; m_rel = 1; m_ctrl = '0; m_stall = 0;
      end else begin
        m_waited++;
        if (m_waited == MOC_TIMEOUT) begin
          m_busy = 0; m_rel = 1; m_ctrl = '0; m_stall = 0; m_err = 1;
        end
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else begin
      m_ctrl = looked;
      if (looked[5]) begin
        m_busy = 1; m_stall = 1; m_waited = 0;
      end
    end
    if (tbl_we) m_tbl[tbl_addr] = tbl_wdata;
  endtask
  task automatic step();
    @(posedge CLK);
    model_edge();
    exp_q.push_back({m_ctrl, m_stall, m_err});
    @(negedge CLK);
  endtask
  task automatic wr(input int a, input logic [CW_W-1:0] d);
    tbl_we = 1; tbl_addr = STATE_W'(a); tbl_wdata = d;
    step();
    tbl_we = 0;
  endtask
  // monitor: every cycle the registered outputs are compared with the oldest expectation
  initial forever begin
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      logic [CW_W+1:0] e;
      e = exp_q.pop_front();
      total++;
      if ({ctrl, stall, err_timeout} !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got ctrl=%h stall=%b err=%b want ctrl=%h stall=%b err=%b",
                 $time, ctrl, stall, err_timeout, e[CW_W+1:2], e[1], e[0]);
      end
    end
  end
  task automatic direct(input string name, input logic [CW_W+1:0] got, input logic [CW_W+1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  initial begin
    int movs;
    foreach (m_tbl[i]) m_tbl[i] = '0;
    step(); step();
    CLR = 1; state = 5;
    repeat (3) step();
    wr(9, 48'h0000_0000_1005);
    state = 9; step(); step();
    wr(6, 48'hC1);
    state = 6; cond = 1; ir_s = 0; step(); step();
    ir_s = 1; step(); step();
    wr(6, 48'h1C1);
    cond = 0; step(); step();
    cond = 1; ir_s = 0;
    wr(34, 48'h30);
    state = 34; step();
    state = 0; step(); step();
    moc = 1; step();
    moc = 0; step(); step(); step();
    movs = 0;
    state = 34;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ctrl[5]) movs++;
      state = 0;
    end
    direct("mov_hold", {46'd0, 2'(movs > 15 ? 3 : movs == 15 ? 1 : 0)}, 48'd1);
    err_clr = 1; step(); err_clr = 0; step();
    direct("err_cleared", {47'd0, err_timeout}, '0);
    state = 34; step();
    state = 0;
    err_clr = 1;
    repeat (15) step();
    err_clr = 0;
    direct("err_set_wins", {47'd0, err_timeout}, 48'd1);
    step(); step();
    wr(3, 48'h7);
    state = 3;
    wr(3, 48'h2);
    step(); step();
    wr(40, 48'hABC0_0030);
    state = 40; step();
    state = 0; step();
    #2 CLR = 0;
    #1 direct("async_rst", {ctrl, stall, err_timeout}, '0);
    step();
    CLR = 1; state = 9; step(); step();
    for (int i = 0; i < 300; i++) begin
      tbl_we    = ($urandom_range(0, 3) == 0);
      tbl_addr  = STATE_W'($urandom_range(0, 15));
      tbl_wdata = {$urandom(), $urandom()} & {36'hFFFF_FFFF_F, 3'b0, 9'h1FF};
      state     = STATE_W'($urandom_range(0, 15));
      cond      = 1'($urandom);
      ir_s      = 1'($urandom);
      moc       = ($urandom_range(0, 9) < 2);
      err_clr   = ($urandom_range(0, 19) == 0);
      step();
    end
    tbl_we = 0;
    repeat (2) @(negedge CLK);
    direct("queue_drained", 48'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctrl_word_encoder.md
Name: ctrl_word_encoder

Overview:
- Parametrised, registered successor to the CPU control unit's hard-coded state-to-control-signal encoder.
- Control words live in a writable table indexed by the sequencer's state number.
- Adds condition gating and S-bit qualification of the flag load.
- Adds a memory handshake on MOV/moc with stall back to the state sequencer and a timeout. Sits between the state register and the datapath muxes, register file, MAR/MDR and memory interface.

Parameters:
- STATE_W, 7, width of state number; table depth = 2**STATE_W.
- CW_W, 48, control word width; must be >= 12.
- TO_W, 4, width of moc timeout counter.
- MOC_TIMEOUT, 15, cycles waited for moc before abort; 1..2**TO_W-1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- state  in  STATE_W  current sequencer state.
- cond  in  1  condition-code result for current instruction.
- ir_s  in  1  S bit of instruction (IR[20]).
- moc  in  1  memory operation complete.
- tbl_we  in  1  table write enable.
- tbl_addr  in  STATE_W  table write address.
- tbl_wdata  in  CW_W  table write data.
- err_clr  in  1  clears err_timeout.
- ctrl  out  CW_W  registered control word to datapath.
- stall  out  1  registered; sequencer must hold state while high.
- err_timeout  out  1  sticky moc-timeout flag.

Behaviour:
- Control word layout:
  - bit0 RFLd, bit1 IRLd, bit2 MARLd, bit3 MDRLd, bit4 RW, bit5 MOV, bit6 FRLd.
  - bit7 SQ: FRLd only if ir_s.
  - bit8 CQ: suppress load enables if cond=0.
  - bits 11:9 reserved; write as 0; driven 0 on ctrl.
  - bits CW_W-1:12 pass-through mux/ALU/shifter selects.
- Gating, applied to the word read from table[state]:
  - SQ=1 and ir_s=0 -> bit6 forced 0.
  - CQ=1 and cond=0 -> bits 0..6 forced 0; pass-through bits kept.
  - bits 8:7 always 0 on ctrl.
- Reset (CLR=0, async): ctrl=0, stall=0, err_timeout=0, counter=0, FSM=RUN, every table entry=0. All-zero entries decode as NOP.
- Table write: synchronous, takes effect at the edge. A lookup in the same cycle to the same address reads the old contents. Writes are accepted in any FSM state.
- FSM RUN:
  - Each edge, ctrl <= gated(table[state]). Latency from state to ctrl is 1 cycle.
  - If the gated MOV=1 -> go to MEM_WAIT, stall<=1, counter<=0, in the same edge that loads ctrl.
- FSM MEM_WAIT:
  - ctrl held unchanged; state input ignored.
  - moc=1 at an edge -> ctrl<=0, stall<=0, go to RELEASE.
  - Otherwise counter++. When counter reaches MOC_TIMEOUT-1 with moc=0 -> ctrl<=0, stall<=0, err_timeout<=1, go to RELEASE.
  - Total MOV hold on timeout is exactly MOC_TIMEOUT cycles.
- FSM RELEASE: one cycle, ctrl stays 0 and stall=0 so the sequencer advances. Next edge -> RUN. This prevents the old state from re-triggering MOV.
- moc high in RUN or RELEASE: ignored.
- err_timeout:
  - Set by timeout; cleared by err_clr=1.
  - Set has priority over clear in the same edge.
- Reset asserted mid-MEM_WAIT: ctrl and stall drop immediately, asynchronously, and the table is cleared. After release, all states decode as NOP until rewritten.
- Back-to-back MOV states: each one passes through MEM_WAIT -> RELEASE, so there is a minimum 1 NOP cycle between memory ops.

Test Plan:
- Reset then read: CLR=0 then 1, state=5 -> ctrl=0, stall=0 on every cycle.
- Plain lookup: write table[9]=48'h0000_0000_1005 (bits 12, 2, 0); state=9 -> next cycle ctrl=48'h1005, stall=0.
- Gating:
  - table[6] = bits 0, 6, 7 set; ir_s=0 -> ctrl=0x001.
  - ir_s=1 -> ctrl=0x041.
  - table[6] with CQ set, cond=0 -> ctrl=0x000.
- Memory handshake: table[34] = bits 4, 5 (0x30); state=34 -> ctrl=0x30, stall=1. moc high in the 3rd wait cycle -> next edge ctrl=0, stall=0, one RELEASE cycle, then lookup of the new state.
- Timeout: MOC_TIMEOUT=15, moc held 0 -> MOV high for exactly 15 cycles, then ctrl=0, err_timeout=1. err_clr=1 clears it; err_clr together with a new timeout -> stays 1.
- Write/read collision and reset mid-wait:
  - Write table[3]=0x2 while state=3 -> first ctrl=old value, next cycle 0x2.
  - CLR low during MEM_WAIT -> stall=0 without waiting for a clock edge.
